// File: rtl/exu_sequencer_pkg.sv
// exu_seq_pkg: shared state encoding, fault codes and instruction size for the sequencer
package exu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [1:0]  ERR_NONE   = 2'b00;
    localparam logic [1:0]  ERR_TMO    = 2'b01;
    localparam logic [1:0]  ERR_ALIGN  = 2'b10;
    localparam logic [31:0] INST_BYTES = 32'd4;

endpackage

// File: rtl/exu_sequencer_if.sv
// exu_sequencer_if: IFU/IDU/EXU/LSU handshake bundle between the sequencer and the core
interface exu_sequencer_if;

    logic        ifu_req;
    logic        ifu_valid;
    logic [31:0] ifu_inst;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        is_load;
    logic        is_store;
    logic        rd_wen;
    logic        brchen;
    logic        jump;
    logic [31:0] target;
    logic        brken;
    logic        lsu_req;
    logic        lsu_ready;
    logic        rf_wen;
    logic        halted;
    logic        err;
    logic [1:0]  err_code;
    logic [63:0] cycle_cnt;
    logic [63:0] instret;

    modport master (
        output ifu_req, inst, pc, lsu_req, rf_wen, halted, err, err_code, cycle_cnt, instret,
        input  ifu_valid, ifu_inst, is_load, is_store, rd_wen, brchen, jump, target, brken, lsu_ready
    );

    modport slave (
        input  ifu_req, inst, pc, lsu_req, rf_wen, halted, err, err_code, cycle_cnt, instret,
        output ifu_valid, ifu_inst, is_load, is_store, rd_wen, brchen, jump, target, brken, lsu_ready
    );

endinterface

// File: rtl/exu_sequencer_perf_counter.sv
// perf_counter: 64-bit free-wrapping event counter with enable and asynchronous clear
module perf_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q;

    // count enabled cycles, wrapping naturally at 2^64
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + 64'd1;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/exu_sequencer.sv
// exu_sequencer: multi-cycle FETCH/EXEC/MEM/WB control, PC ownership, halt/fault handling
module exu_sequencer
    import exu_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int          MEM_TIMEOUT = 255,
    parameter int          TMO_W       = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    exu_sequencer_if.master bus
);

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              redirect;
    logic [TMO_W-1:0]  tmo_inc;

    assign redirect = bus.brchen | bus.jump;
    assign tmo_inc  = tmo_q + TMO_W'(1);

    // state, PC, latched instruction, timeout and sticky fault registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            tmo_q      <= '0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            tmo_q      <= tmo_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // next-state: fault checks take priority in EXEC, and lsu_ready beats the timeout in MEM
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        tmo_d      = tmo_q;
        halted_d   = halted_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (bus.ifu_valid) begin
                    inst_d  = bus.ifu_inst;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.brken) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (redirect && bus.target[1:0] != 2'b00) begin
                    state_d    = S_ERROR;
                    err_d      = 1'b1;
                    err_code_d = ERR_ALIGN;
                end else if (bus.is_load || bus.is_store) begin
                    state_d = S_MEM;
                    tmo_d   = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (bus.lsu_ready) begin
                    state_d = S_WB;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_W'(MEM_TIMEOUT)) begin
                        state_d    = S_ERROR;
                        err_d      = 1'b1;
                        err_code_d = ERR_TMO;
                    end
                end
            end
            S_WB: begin
                pc_d    = redirect ? bus.target : pc_q + INST_BYTES;
                state_d = S_FETCH;
            end
            default: ;
        endcase
    end

    assign bus.ifu_req  = state_q == S_FETCH;
    assign bus.lsu_req  = state_q == S_MEM;
    assign bus.rf_wen   = (state_q == S_WB) & bus.rd_wen & ~bus.is_store;
    assign bus.inst     = inst_q;
    assign bus.pc       = pc_q;
    assign bus.halted   = halted_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;

    perf_counter u_cycle (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (state_q != S_HALT && state_q != S_ERROR),
        .cnt_o (bus.cycle_cnt)
    );

    perf_counter u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (state_q == S_WB),
        .cnt_o (bus.instret)
    );

endmodule

// File: tb/tb_exu_sequencer.sv
// tb_exu_sequencer: directed vectors on a default DUT and a MEM_TIMEOUT=4 DUT sharing stimulus
module tb_exu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_valid, is_load, is_store, rd_wen, brchen, jump, brken, lsu_ready;
    logic [31:0] ifu_inst, target;
    int          n_vec = 0;
    int          n_bad = 0;

    exu_sequencer_if b0 ();
    exu_sequencer_if b4 ();

    assign b0.ifu_valid = ifu_valid;
    assign b0.ifu_inst  = ifu_inst;
    assign b0.is_load   = is_load;
    assign b0.is_store  = is_store;
    assign b0.rd_wen    = rd_wen;
    assign b0.brchen    = brchen;
    assign b0.jump      = jump;
    assign b0.target    = target;
    assign b0.brken     = brken;
    assign b0.lsu_ready = lsu_ready;
    assign b4.ifu_valid = ifu_valid;
    assign b4.ifu_inst  = ifu_inst;
    assign b4.is_load   = is_load;
    assign b4.is_store  = is_store;
    assign b4.rd_wen    = rd_wen;
    assign b4.brchen    = brchen;
    assign b4.jump      = jump;
    assign b4.target    = target;
    assign b4.brken     = brken;
    assign b4.lsu_ready = lsu_ready;

    exu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    exu_sequencer #(.MEM_TIMEOUT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ifu_valid = 0; is_load = 0; is_store = 0; rd_wen = 0; brchen = 0;
        jump = 0; brken = 0; lsu_ready = 0; ifu_inst = '0; target = '0;
    endtask

    task automatic reset_dut();
        rst_n = 0;
        clr();
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        clr();
        reset_dut();
        check("rst_pc", b0.pc, 32'h8000_0000);
        check("rst_inst", b0.inst, 0);
        check("rst_ifu_req", b0.ifu_req, 0);
        check("rst_lsu_req", b0.lsu_req, 0);
        check("rst_cycle", b0.cycle_cnt, 0);
        check("rst_err", {b0.halted, b0.err, b0.err_code}, 0);
        // ALU retire, zero-wait IFU
        step();
        check("alu_fetch_req", b0.ifu_req, 1);
        ifu_valid = 1; ifu_inst = 32'h0050_0093; rd_wen = 1;
        step();
        ifu_inst = 32'hdead_beef;
        check("alu_exec_inst", b0.inst, 32'h0050_0093);
        check("alu_exec_ifu_req", b0.ifu_req, 0);
        check("alu_exec_rf_wen", b0.rf_wen, 0);
        step();
        ifu_valid = 0;
        check("alu_wb_rf_wen", b0.rf_wen, 1);
        check("alu_wb_inst_held", b0.inst, 32'h0050_0093);
        check("alu_wb_pc", b0.pc, 32'h8000_0000);
        step();
        check("alu_next_rf_wen", b0.rf_wen, 0);
        check("alu_next_pc", b0.pc, 32'h8000_0004);
        check("alu_instret", b0.instret, 1);
        check("alu_cycle", b0.cycle_cnt, 4);
        // fetch stall, then taken branch with rd_wen=0
        step();
        check("br_stall_req", b0.ifu_req, 1);
        check("br_stall_pc", b0.pc, 32'h8000_0004);
        ifu_valid = 1; ifu_inst = 32'h0000_0463; rd_wen = 0;
        step();
        ifu_valid = 0; brchen = 1; target = 32'h8000_0010;
        step();
        check("br_wb_rf_wen", b0.rf_wen, 0);
        step();
        brchen = 0;
        check("br_pc", b0.pc, 32'h8000_0010);
        check("br_instret", b0.instret, 2);
        // jump to the top of the address space, then wrap to 0
        ifu_valid = 1;
        step();
        ifu_valid = 0; jump = 1; target = 32'hFFFF_FFFC; rd_wen = 1;
        step();
        check("jmp_wb_rf_wen", b0.rf_wen, 1);
        step();
        jump = 0; rd_wen = 0;
        check("jmp_pc", b0.pc, 32'hFFFF_FFFC);
        ifu_valid = 1;
        step();
        ifu_valid = 0;
        step();
        step();
        check("wrap_pc", b0.pc, 32'h0000_0000);
        check("wrap_instret", b0.instret, 4);
        // load with 5 wait cycles
        reset_dut();
        step();
        ifu_valid = 1; ifu_inst = 32'h0000_2103;
        step();
        ifu_valid = 0; is_load = 1; rd_wen = 1;
        step();
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("ld_lsu_req%0d", k), b0.lsu_req, 1);
            check($sformatf("ld_rf_wen%0d", k), b0.rf_wen, 0);
            if (k == 6) lsu_ready = 1;
            step();
        end
        lsu_ready = 0;
        check("ld_wb_lsu_req", b0.lsu_req, 0);
        check("ld_wb_rf_wen", b0.rf_wen, 1);
        check("ld_wb_cycle", b0.cycle_cnt, 9);
        check("ld_wb_err", b0.err, 0);
        step();
        is_load = 0; rd_wen = 0;
        check("ld_instret", b0.instret, 1);
        check("ld_pc", b0.pc, 32'h8000_0004);
        // timeout on the MEM_TIMEOUT=4 instance
        reset_dut();
        step();
        ifu_valid = 1;
        step();
        ifu_valid = 0; is_load = 1; rd_wen = 1;
        step();
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("tmo_lsu_req%0d", k), b4.lsu_req, 1);
            check($sformatf("tmo_err%0d", k), b4.err, 0);
            step();
        end
        check("tmo_err", b4.err, 1);
        check("tmo_err_code", b4.err_code, 2'b01);
        check("tmo_lsu_req_off", b4.lsu_req, 0);
        check("tmo_cycle", b4.cycle_cnt, 7);
        check("tmo_big_still_waiting", b0.lsu_req, 1);
        check("tmo_big_no_err", b0.err, 0);
        repeat (3) step();
        check("tmo_cycle_frozen", b4.cycle_cnt, 7);
        check("tmo_instret", b4.instret, 0);
        check("tmo_ifu_req", b4.ifu_req, 0);
        // lsu_ready on the limit cycle wins over the timeout
        reset_dut();
        step();
        ifu_valid = 1;
        step();
        ifu_valid = 0; is_load = 1; rd_wen = 1;
        step();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) lsu_ready = 1;
            step();
        end
        lsu_ready = 0;
        check("lim_err", b4.err, 0);
        check("lim_rf_wen", b4.rf_wen, 1);
        step();
        check("lim_instret", b4.instret, 1);
        check("lim_ifu_req", b4.ifu_req, 1);
        // ebreak
        reset_dut();
        step();
        ifu_valid = 1; ifu_inst = 32'h0010_0073;
        step();
        ifu_valid = 0; brken = 1;
        step();
        check("brk_halted", b0.halted, 1);
        check("brk_err", b0.err, 0);
        check("brk_ifu_req", b0.ifu_req, 0);
        ifu_valid = 1;
        repeat (3) step();
        check("brk_ifu_req_held", b0.ifu_req, 0);
        check("brk_instret", b0.instret, 0);
        check("brk_cycle", b0.cycle_cnt, 3);
        check("brk_halted_held", b0.halted, 1);
        // misaligned jump target
        reset_dut();
        step();
        ifu_valid = 1;
        step();
        ifu_valid = 0; jump = 1; target = 32'h8000_0002;
        step();
        check("mis_err", b0.err, 1);
        check("mis_err_code", b0.err_code, 2'b10);
        check("mis_halted", b0.halted, 0);
        check("mis_pc", b0.pc, 32'h8000_0000);
        check("mis_rf_wen", b0.rf_wen, 0);
        // asynchronous reset in the middle of a store
        reset_dut();
        step();
        ifu_valid = 1; ifu_inst = 32'h0050_0093; rd_wen = 1;
        step();
        ifu_valid = 0;
        step();
        step();
        ifu_valid = 1; rd_wen = 0;
        step();
        ifu_valid = 0; is_store = 1;
        step();
        check("ar_lsu_req", b0.lsu_req, 1);
        check("ar_pc", b0.pc, 32'h8000_0004);
        #2;
        rst_n = 0;
        #1;
        check("ar_lsu_req_off", b0.lsu_req, 0);
        check("ar_pc_reset", b0.pc, 32'h8000_0000);
        check("ar_inst_reset", b0.inst, 0);
        check("ar_instret_reset", b0.instret, 0);
        clr();
        rst_n = 1;
        check("ar_idle_ifu_req", b0.ifu_req, 0);
        step();
        check("ar_fetch_ifu_req", b0.ifu_req, 1);
        step();
        check("ar_fetch_hold", b0.ifu_req, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
